uart_bram_host_initiator: RTL and testbench
===========================================

# uart_bram_host_initiator

Host-side command initiator for the UART BRAM command protocol. It accepts one operation at a time from local logic (READ, WRITE, ERASE), serialises the command byte and write payload into a UART transmitter, and collects read-back bytes from a UART receiver into a local stream. It sits between local control logic and a UART TX/RX core pair, facing the BRAM controller across the serial link.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width on all data paths
- LEN_WIDTH, 12, width of byte counters
- MAX_LEN, 4096, maximum bytes sent or received per operation
- TO_WIDTH, 20, width of the timeout counter
- IDLE_TIMEOUT, 100000, clk cycles without a received byte that end a READ
- ERASE_WAIT, 8192, clk cycles held in ERASE after the command byte

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  operation request
- cmd_op  input  2  1=READ, 2=WRITE, 3=ERASE; 0 rejected
- cmd_ready  output  1  high only in IDLE
- wr_data  input  DATA_WIDTH  WRITE payload byte
- wr_valid  input  1  payload byte available
- wr_last  input  1  marks final payload byte
- wr_ready  output  1  payload byte accepted this cycle
- rd_data  output  DATA_WIDTH  received READ byte
- rd_valid  output  1  one-cycle pulse per received byte
- tx_start  output  1  one-cycle start pulse to UART TX
- tx_data  output  DATA_WIDTH  byte for UART TX, stable from tx_start until tx_busy falls
- tx_busy  input  1  UART TX busy level
- rx_data  input  DATA_WIDTH  UART RX byte
- rx_done  input  1  UART RX byte-complete level (edge-detected internally)
- done  output  1  one-cycle pulse at end of every operation
- err  output  1  one-cycle pulse with done on abnormal end
- count  output  LEN_WIDTH  bytes sent (WRITE) or received (READ) in last operation

## Operation
- Protocol constants: READ 8'h11, WRITE 8'h12, ERASE 8'h13, terminator ESC 8'h1B.
- States: IDLE, SEND, WAIT_HI, WAIT_LO, LOAD, RECV, ERASE_HOLD, FINISH.
- IDLE: cmd_ready=1. On cmd_valid with op 1..3: latch op, clear count, tx_data<=command byte, go SEND. Op 0: pulse done and err, stay IDLE.
- SEND: if tx_busy low, pulse tx_start, go WAIT_HI; else wait.
- WAIT_HI: wait for tx_busy high; if not seen within 16 cycles, proceed as if byte sent (handles fast TX cores). Then WAIT_LO: wait for tx_busy low, then branch on what was sent:
  - command byte, op READ -> RECV; op ERASE -> ERASE_HOLD; op WRITE -> LOAD.
  - payload byte -> LOAD, unless byte was wr_last or count==MAX_LEN-1, then tx_data<=ESC, SEND.
  - ESC -> FINISH.
- LOAD (WRITE): wr_ready=1; on wr_valid: tx_data<=wr_data, count+1, go SEND. Payload byte equal to 8'h12 or 8'h1B: still consumed, not sent, err flagged at done, operation continues with ESC immediately.
- RECV: on each rx_done rising edge: rd_data<=rx_data, rd_valid pulse, count+1, timeout cleared. End when count reaches MAX_LEN or timeout reaches IDLE_TIMEOUT -> FINISH. Zero received bytes at timeout: err with done.
- ERASE_HOLD: count ERASE_WAIT cycles, ignore rx, -> FINISH.
- FINISH: pulse done (and err if flagged), -> IDLE.
- rx_done edges outside RECV are discarded.

## Timing
- Reset (rst low, async): state IDLE; cmd_ready 1 after reset release; all other outputs 0 (tx_data, rd_data, count = 0). Reset mid-operation aborts immediately; no ESC is sent.
- cmd_valid sampled at clk edge in IDLE; tx_start earliest 2 cycles after acceptance.
- tx_start never asserted while tx_busy high; never two pulses without intervening WAIT_LO exit.
- rd_valid 2 cycles after rx_done rising edge (1 sync/edge register, 1 output register).
- wr_ready one cycle wide per byte; at most one payload byte per TX byte time.
- done pulse 1 cycle after terminating condition; cmd_ready rises the cycle after done.
- count saturates at MAX_LEN; timeout counter saturates at IDLE_TIMEOUT.

## Test plan
- WRITE 3 bytes 8'h41,8'h42,8'h43(wr_last) with TX model busy 10 cycles/byte -> tx sequence 12,41,42,43,1B; count=3; done, no err.
- READ with RX model delivering 8'h55,8'hAA then silence -> tx 11; rd_valid twice with 55,AA; done IDLE_TIMEOUT cycles after last byte; count=2, no err.
- ERASE -> tx 13; rx_done pulses during hold produce no rd_valid; done exactly ERASE_WAIT+1 cycles after tx_busy falls.
- WRITE payload containing 8'h1B as 2nd byte -> tx 12,first,1B only; done with err; count=1.
- cmd_op=0, and READ with no response -> each gives done+err; count=0.
- Assert rst low during WRITE payload -> outputs 0 immediately, no further tx_start; new READ after release runs normally.

Source files
------------

// File: rtl/uart_bram_host_initiator.sv
// Host-side initiator for the UART BRAM command protocol.
// Takes one READ/WRITE/ERASE at a time, pushes the command byte and any write
// payload (ESC-terminated) through a UART TX core, and streams read-back bytes
// from a UART RX core out on rd_data/rd_valid.
module uart_bram_host_initiator #(
   parameter int DATA_WIDTH   = 8,
   parameter int LEN_WIDTH    = 12,
   parameter int MAX_LEN      = 4096,
   parameter int TO_WIDTH     = 20,
   parameter int IDLE_TIMEOUT = 100000,
   parameter int ERASE_WAIT   = 8192
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   input  logic [1:0]            cmd_op,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   input  logic                  wr_last,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_busy,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_done,
   output logic                  done,
   output logic                  err,
   output logic [LEN_WIDTH-1:0]  count
);

   typedef enum logic [2:0] {
      IDLE, SEND, WAIT_HI, WAIT_LO, LOAD, RECV, ERASE_HOLD, FINISH
   } state_t;

   // What the byte currently in flight on TX is, so WAIT_LO knows where to go.
   typedef enum logic [1:0] {K_CMD, K_DATA, K_ESC} kind_t;

   localparam logic [DATA_WIDTH-1:0] B_READ  = DATA_WIDTH'(8'h11);
   localparam logic [DATA_WIDTH-1:0] B_WRITE = DATA_WIDTH'(8'h12);
   localparam logic [DATA_WIDTH-1:0] B_ERASE = DATA_WIDTH'(8'h13);
   localparam logic [DATA_WIDTH-1:0] B_ESC   = DATA_WIDTH'(8'h1B);

   // Byte counter is one bit wider than the port so it can hold MAX_LEN itself.
   localparam logic [LEN_WIDTH:0]  CNT_MAX  = (LEN_WIDTH+1)'(MAX_LEN);
   localparam logic [LEN_WIDTH:0]  CNT_LAST = (LEN_WIDTH+1)'(MAX_LEN - 1);
   localparam logic [LEN_WIDTH:0]  CNT_ONE  = (LEN_WIDTH+1)'(1);
   localparam logic [TO_WIDTH-1:0] TMR_ONE  = TO_WIDTH'(1);
   localparam logic [TO_WIDTH-1:0] HI_LIM   = TO_WIDTH'(15);
   localparam logic [TO_WIDTH-1:0] IDLE_LIM = TO_WIDTH'(IDLE_TIMEOUT - 1);
   localparam logic [TO_WIDTH-1:0] ERA_LIM  = TO_WIDTH'(ERASE_WAIT - 1);

   state_t                state_q, state_d;
   kind_t                 kind_q, kind_d;
   logic [1:0]            op_q, op_d;
   logic                  last_q, last_d;
   logic                  eflag_q, eflag_d;
   logic [LEN_WIDTH:0]    cnt_q, cnt_d, cnt_inc;
   logic [TO_WIDTH-1:0]   tmr_q, tmr_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  rx_sync_q, rx_sync_d;
   logic                  rx_prev_q, rx_prev_d;
   logic                  rx_rise;

   assign cmd_ready = (state_q == IDLE);
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;
   // A full MAX_LEN transfer does not fit the port; report all-ones then.
   assign count     = cnt_q[LEN_WIDTH] ? '1 : cnt_q[LEN_WIDTH-1:0];

   assign rx_rise = rx_sync_q & ~rx_prev_q;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Next-state and output decode for the operation sequencer.
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      op_d       = op_q;
      last_d     = last_q;
      eflag_d    = eflag_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      tx_data_d  = tx_data_q;
      rd_data_d  = rd_data_q;
      tx_start_d = 1'b0;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wr_ready   = 1'b0;
      rx_sync_d  = rx_done;
      rx_prev_d  = rx_sync_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cnt_d = '0;
               if (cmd_op == 2'd0) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  op_d    = cmd_op;
                  kind_d  = K_CMD;
                  last_d  = 1'b0;
                  eflag_d = 1'b0;
                  case (cmd_op)
                     2'd1:    tx_data_d = B_READ;
                     2'd2:    tx_data_d = B_WRITE;
                     default: tx_data_d = B_ERASE;
                  endcase
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tmr_d      = '0;
               state_d    = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // A TX core that finishes before we see busy is treated as done.
            if (tx_busy || tmr_q == HI_LIM) state_d = WAIT_LO;
            else                            tmr_d   = tmr_q + TMR_ONE;
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               case (kind_q)
                  K_CMD: begin
                     tmr_d = '0;
                     if (op_q == 2'd1)      state_d = RECV;
                     else if (op_q == 2'd3) state_d = ERASE_HOLD;
                     else                   state_d = LOAD;
                  end
                  K_DATA: begin
                     if (last_q || cnt_q == CNT_LAST) begin
                        tx_data_d = B_ESC;
                        kind_d    = K_ESC;
                        state_d   = SEND;
                     end else begin
                        state_d = LOAD;
                     end
                  end
                  default: begin
                     state_d = FINISH;
                     done_d  = 1'b1;
                     err_d   = eflag_q;
                  end
               endcase
            end
         end
         LOAD: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               // Protocol bytes cannot be carried as payload: drop, terminate.
               if (wr_data == B_WRITE || wr_data == B_ESC) begin
                  eflag_d   = 1'b1;
                  tx_data_d = B_ESC;
                  kind_d    = K_ESC;
               end else begin
                  tx_data_d = wr_data;
                  cnt_d     = cnt_inc;
                  kind_d    = K_DATA;
                  last_d    = wr_last;
               end
               state_d = SEND;
            end
         end
         RECV: begin
            if (rx_rise) begin
               rd_data_d  = rx_data;
               rd_valid_d = 1'b1;
               cnt_d      = cnt_inc;
               tmr_d      = '0;
               if (cnt_q == CNT_LAST) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end
            end else if (tmr_q >= IDLE_LIM) begin
               state_d = FINISH;
               done_d  = 1'b1;
               err_d   = (cnt_q == '0);
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         ERASE_HOLD: begin
            if (tmr_q >= ERA_LIM) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         kind_q     <= K_CMD;
         op_q       <= '0;
         last_q     <= 1'b0;
         eflag_q    <= 1'b0;
         cnt_q      <= '0;
         tmr_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rx_sync_q  <= 1'b0;
         rx_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         op_q       <= op_d;
         last_q     <= last_d;
         eflag_q    <= eflag_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
      end
   end

endmodule

// File: tb/tb_uart_bram_host_initiator.sv
// Directed bench for uart_bram_host_initiator with behavioural TX/RX stand-ins.
module tb_uart_bram_host_initiator;
   localparam int DW = 8;
   localparam int LW = 12;
   localparam int TO = 200;
   localparam int EW = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] wr_data;
   logic          wr_valid, wr_last, wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid, tx_start;
   logic [DW-1:0] tx_data;
   logic          tx_busy;
   logic [DW-1:0] rx_data;
   logic          rx_done, done, err;
   logic [LW-1:0] count;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int fall_cyc, busy_viol, bcnt, done_cyc, rx_cyc0;
   logic done_err;
   logic [7:0] tx_log[$];
   logic [7:0] rd_log[$];
   int         rdv_cyc[$];

   uart_bram_host_initiator #(
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_LEN(4096), .TO_WIDTH(20),
      .IDLE_TIMEOUT(TO), .ERASE_WAIT(EW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_done(rx_done),
      .done(done), .err(err), .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare the logged TX byte stream (byte 0 in the low bits) and its length.
   task automatic chk_tx(input string tag, input int n, input logic [39:0] exp);
      logic [39:0] obs = '0;
      for (int i = 0; i < tx_log.size() && i < 5; i++) obs[8*i +: 8] = tx_log[i];
      chk({tag, "_n"}, tx_log.size(), n);
      chk(tag, obs, exp);
   endtask

   // TX core stand-in: busy for 10 cycles per byte; flags a start while busy
   // or tx_data moving while busy.
   initial begin
      tx_busy = 1'b0; bcnt = 0; busy_viol = 0; fall_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            tx_busy = 1'b0;
            bcnt    = 0;
         end else if (tx_start) begin
            if (tx_busy) busy_viol++;
            tx_log.push_back(tx_data);
            tx_busy = 1'b1;
            bcnt    = 10;
         end else if (tx_busy) begin
            if (tx_log.size() > 0 && tx_data !== tx_log[tx_log.size()-1]) busy_viol++;
            bcnt--;
            if (bcnt == 0) begin
               tx_busy  = 1'b0;
               fall_cyc = cyc;
            end
         end
      end
   end

   // Read-stream logger.
   initial forever begin
      @(negedge clk);
      if (rd_valid) begin
         rd_log.push_back(rd_data);
         rdv_cyc.push_back(cyc);
      end
   end

   task automatic clear_logs();
      tx_log.delete(); rd_log.delete(); rdv_cyc.delete();
   endtask

   task automatic issue(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] d, input logic last);
      bit acc = 0;
      wr_data  = d;
      wr_last  = last;
      wr_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (wr_ready) begin
            acc = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      chk("wr_accept", acc, 1);
   endtask

   task automatic rx_byte(input logic [7:0] d);
      rx_data = d;
      rx_done = 1'b1;
      rx_cyc0 = cyc;
      repeat (3) @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit got = 0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      done_cyc = cyc;
      done_err = err;
      chk("done_seen", got, 1);
   endtask

   int n_before, first_rx;

   initial begin
      cmd_valid = 1'b0; cmd_op = 2'd0;
      wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
      rx_data = '0; rx_done = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctl", {tx_start, rd_valid, done, err, wr_ready}, 5'b0);
      chk("rst_txd", tx_data, 0);
      chk("rst_cnt", count, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rdy", cmd_ready, 1);

      // WRITE 41 42 43(last)
      clear_logs();
      issue(2'd2);
      wr_byte(8'h41, 1'b0);
      wr_byte(8'h42, 1'b0);
      wr_byte(8'h43, 1'b1);
      wait_done(200);
      chk("wr_err", done_err, 0);
      chk("wr_cnt", count, 3);
      chk("wr_rdy_at_done", cmd_ready, 0);
      @(negedge clk);
      chk("wr_rdy_after", cmd_ready, 1);
      chk_tx("wr_seq", 5, 40'h1B_43_42_41_12);

      // READ with two bytes then silence
      clear_logs();
      issue(2'd1);
      repeat (30) @(negedge clk);
      rx_byte(8'h55);
      first_rx = rx_cyc0;
      repeat (10) @(negedge clk);
      rx_byte(8'hAA);
      wait_done(TO + 50);
      chk("rd_n", rd_log.size(), 2);
      chk("rd_b0", rd_log[0], 8'h55);
      chk("rd_b1", rd_log[1], 8'hAA);
      chk("rd_lat", rdv_cyc[0] - first_rx, 2);
      chk("rd_idle_gap", done_cyc - rdv_cyc[1], TO);
      chk("rd_cnt", count, 2);
      chk("rd_err", done_err, 0);
      chk_tx("rd_seq", 1, 40'h11);
      @(negedge clk);

      // ERASE, rx noise during hold must be ignored
      clear_logs();
      issue(2'd3);
      repeat (20) @(negedge clk);
      rx_byte(8'h5A);
      repeat (5) @(negedge clk);
      rx_byte(8'h5B);
      wait_done(100);
      chk("er_rd_n", rd_log.size(), 0);
      chk("er_hold", done_cyc - fall_cyc, EW + 1);
      chk("er_err", done_err, 0);
      chk("er_cnt", count, 0);
      chk_tx("er_seq", 1, 40'h13);
      @(negedge clk);

      // WRITE with ESC as second payload byte
      clear_logs();
      issue(2'd2);
      wr_byte(8'h31, 1'b0);
      wr_byte(8'h1B, 1'b0);
      wait_done(200);
      chk("bad_err", done_err, 1);
      chk("bad_cnt", count, 1);
      chk_tx("bad_seq", 3, 40'h1B_31_12);
      @(negedge clk);

      // Op 0 rejected in IDLE
      clear_logs();
      issue(2'd0);
      wait_done(5);
      chk("op0_err", done_err, 1);
      chk("op0_cnt", count, 0);
      @(negedge clk);
      chk("op0_rdy", cmd_ready, 1);
      chk("op0_notx", tx_log.size(), 0);

      // READ with no response
      clear_logs();
      issue(2'd1);
      wait_done(TO + 50);
      chk("nr_err", done_err, 1);
      chk("nr_cnt", count, 0);
      chk("nr_rd_n", rd_log.size(), 0);
      chk_tx("nr_seq", 1, 40'h11);
      @(negedge clk);

      // Reset in the middle of a WRITE payload
      clear_logs();
      issue(2'd2);
      wr_byte(8'h61, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_txn", tx_log.size(), 2);
      rst = 1'b0;
      #1;
      chk("mid_ctl", {tx_start, rd_valid, done, err, wr_ready}, 5'b0);
      chk("mid_txd", tx_data, 0);
      chk("mid_rdd", rd_data, 0);
      chk("mid_cnt", count, 0);
      n_before = tx_log.size();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("mid_no_tx", tx_log.size(), n_before);
      chk("mid_rdy", cmd_ready, 1);

      // READ after reset runs normally
      clear_logs();
      issue(2'd1);
      repeat (30) @(negedge clk);
      rx_byte(8'h77);
      wait_done(TO + 50);
      chk("pr_rd_n", rd_log.size(), 1);
      chk("pr_b0", rd_log[0], 8'h77);
      chk("pr_cnt", count, 1);
      chk("pr_err", done_err, 0);
      chk_tx("pr_seq", 1, 40'h11);

      chk("tx_protocol", busy_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
